// File: rtl/cnn_mac_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_mac_pipe_if                                                      |
// | Operand-in / result-out handshake bundle for cnn_mac_pipe.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface cnn_mac_pipe_if #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 12,
    parameter int DOUT_WIDTH = 24
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         out_ovf;

    modport master (
        output in_valid, din0, din1, in_last, out_ready,
        input  in_ready, out_valid, dout, out_ovf
    );

    modport slave (
        input  in_valid, din0, din1, in_last, out_ready,
        output in_ready, out_valid, dout, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/cnn_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_mac_pipe                                                         |
// | Pipelined signed MAC: accumulate to in_last, shift, saturate.        |
// | Optional macro CNN_MAC_ROUND_EN selects round-half-up scaling.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cnn_mac_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 12,
    parameter int ACC_WIDTH  = 40,
    parameter int DOUT_WIDTH = 24,
    parameter int SHIFT      = 8,
    parameter int NUM_STAGE  = 2
) (
    input  wire logic     ap_clk,
    input  wire logic     ap_rst,
    cnn_mac_pipe_if.slave bus
);

    localparam int C_PROD_W = DIN0_WIDTH + DIN1_WIDTH;

    localparam logic [0:0] ACC_IDLE = 1'b0;
    localparam logic [0:0] ACC_RUN  = 1'b1;

    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MAX =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] C_SAT_MIN = ~C_SAT_MAX;

    logic                       w_enable;
    logic                       w_accept;
    logic signed [C_PROD_W-1:0] w_prod;

    logic [NUM_STAGE-1:0]       vld_q, vld_d;
    logic [NUM_STAGE-1:0]       last_q, last_d;
    logic signed [C_PROD_W-1:0] prod_q [NUM_STAGE];
    logic signed [C_PROD_W-1:0] prod_d [NUM_STAGE];

    logic [0:0]                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

    logic                         out_valid_q, out_valid_d;
    logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                         ovf_q, ovf_d;

    logic                         w_pv;
    logic                         w_pl;
    logic signed [ACC_WIDTH-1:0]  w_prod_ext;
    logic signed [ACC_WIDTH-1:0]  w_base;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic signed [ACC_WIDTH-1:0]  w_sum_r;
    logic signed [ACC_WIDTH-1:0]  w_scaled;
    logic                         w_sat_hi;
    logic                         w_sat_lo;
    logic signed [DOUT_WIDTH-1:0] w_dout_new;
    logic                         w_load;

    // A held result blocks the whole datapath; in_ready also drops during reset.
    assign w_enable     = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = w_enable && !ap_rst;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_prod       = bus.din0 * bus.din1;

    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        prod_d = prod_q;
        if (w_enable) begin
            vld_d[0]  = w_accept;
            last_d[0] = w_accept && bus.in_last;
            prod_d[0] = w_prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_d[i]  = vld_q[i-1];
                last_d[i] = last_q[i-1];
                prod_d[i] = prod_q[i-1];
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
            prod_q <= prod_d;
        end
    end

    assign w_pv       = vld_q[NUM_STAGE-1];
    assign w_pl       = last_q[NUM_STAGE-1];
    assign w_prod_ext = ACC_WIDTH'(prod_q[NUM_STAGE-1]);

    // Accumulator FSM: state register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= ACC_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Accumulator FSM: next state
    always_comb begin
        state_d = state_q;
        if (w_enable && w_pv) begin
            state_d = w_pl ? ACC_IDLE : ACC_RUN;
        end
    end

    // Accumulator FSM: outputs (accumulator update and result load strobe)
    always_comb begin
        w_base = (state_q == ACC_RUN) ? acc_q : '0;
        w_sum  = w_base + w_prod_ext;
        acc_d  = acc_q;
        w_load = 1'b0;
        if (w_enable && w_pv) begin
            acc_d  = w_pl ? '0 : w_sum;
            w_load = w_pl;
        end
    end

`ifdef CNN_MAC_ROUND_EN
    localparam int C_RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH-1:0] C_ROUND =
        (SHIFT > 0) ? (ACC_WIDTH'(1) << C_RSH) : '0;
    assign w_sum_r = w_sum + C_ROUND;
`else
    assign w_sum_r = w_sum;
`endif

    assign w_scaled   = w_sum_r >>> SHIFT;
    assign w_sat_hi   = w_scaled > C_SAT_MAX;
    assign w_sat_lo   = w_scaled < C_SAT_MIN;
    assign w_dout_new = w_sat_hi ? C_SAT_MAX[DOUT_WIDTH-1:0] :
                        w_sat_lo ? C_SAT_MIN[DOUT_WIDTH-1:0] :
                                   w_scaled[DOUT_WIDTH-1:0];

    // A new result may load on the same edge the previous one is consumed.
    always_comb begin
        out_valid_d = w_load || (out_valid_q && !bus.out_ready);
        dout_d      = w_load ? w_dout_new : dout_q;
        ovf_d       = w_load ? (w_sat_hi || w_sat_lo) : ovf_q;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cnn_mac_pipe                                                      |
// | Directed-vector bench for cnn_mac_pipe (default parameters).         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cnn_mac_pipe;

`ifdef CNN_MAC_ROUND_EN
    localparam longint C_EXP_SINGLE = -234;
`else
    localparam longint C_EXP_SINGLE = -235;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnn_mac_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(12), .DOUT_WIDTH(24)) bus ();

    cnn_mac_pipe #(
        .DIN0_WIDTH(16), .DIN1_WIDTH(12), .ACC_WIDTH(40),
        .DOUT_WIDTH(24), .SHIFT(8), .NUM_STAGE(2)
    ) u_dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus)
    );

    int     n_vec = 0;
    int     n_err = 0;
    longint q_dout [$];
    longint q_ovf  [$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Results are recorded on the falling edge ahead of the consuming rising edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            q_dout.push_back(longint'(bus.dout));
            q_ovf.push_back(longint'(bus.out_ovf));
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input longint a, input longint b, input bit l);
        int n = 0;
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.din0     = 16'(a);
        bus.din1     = 12'(b);
        bus.in_last  = l;
        while (!done && n < 100) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic get_result(input string tag, input longint exp_d, input longint exp_o);
        int n = 0;
        while (q_dout.size() == 0 && n < 200) begin
            tick(1);
            n++;
        end
        if (q_dout.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_dout"}, q_dout.pop_front(), exp_d);
            chk({tag, "_ovf"}, q_ovf.pop_front(), exp_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.din0      = '0;
        bus.din1      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_dout", longint'(bus.dout), 0);
        chk("rst_ovf", longint'(bus.out_ovf), 0);
        chk("rst_in_ready", longint'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // single beat with latency
        send(300, -200, 1'b1);
        chk("single_lat_k0", longint'(bus.out_valid), 0);
        tick(1);
        chk("single_lat_k1", longint'(bus.out_valid), 0);
        tick(1);
        chk("single_lat_k2", longint'(bus.out_valid), 1);
        chk("single_dout_now", longint'(bus.dout), C_EXP_SINGLE);
        get_result("single", C_EXP_SINGLE, 0);

        // three beats with bubbles
        send(100, 10, 1'b0);
        tick(2);
        send(-50, 4, 1'b0);
        tick(3);
        send(7, 7, 1'b1);
        get_result("three", 3, 0);
        tick(10);
        chk("three_count", longint'(q_dout.size()), 0);

        // positive saturation
        for (int i = 0; i < 40; i++) send(32767, 2047, i == 39);
        get_result("sat_pos", 8388607, 1);

        // negative saturation
        for (int i = 0; i < 40; i++) send(-32768, 2047, i == 39);
        get_result("sat_neg", -8388608, 1);

        // back-pressure
        bus.out_ready = 1'b0;
        send(16, 16, 1'b1);
        send(32, 16, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick(1);
            n++;
        end
        chk("stall_valid", longint'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_dout", longint'(bus.dout), 1);
            chk("stall_in_ready", longint'(bus.in_ready), 0);
            tick(1);
        end
        bus.out_ready = 1'b1;
        get_result("stall_r1", 1, 0);
        get_result("stall_r2", 2, 0);
        tick(5);
        chk("stall_count", longint'(q_dout.size()), 0);

        // reset mid-vector
        send(1000, 1000, 1'b0);
        send(1000, 1000, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_dout", longint'(bus.dout), 0);
        chk("midrst_ovf", longint'(bus.out_ovf), 0);
        chk("midrst_in_ready", longint'(bus.in_ready), 0);
        tick(2);
        rst = 1'b0;
        send(16, 16, 1'b1);
        get_result("midrst", 1, 0);
        tick(5);
        chk("midrst_count", longint'(q_dout.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnn_mac_pipe.md
# cnn_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit for the CNN datapath, successor to the fixed single-cycle signed multiplier cores. It accepts a stream of operand pairs with a valid/ready handshake and multiplies them in an NUM_STAGE-deep pipeline. Products are accumulated until a beat flagged `in_last` arrives; the sum is then scaled by an arithmetic right shift, saturated to the output width, and presented on a registered output handshake. It sits between the line-buffer/weight fetch logic and the activation stage of the conv and dense layers.

## Interface
- `DIN0_WIDTH`, 16, signed activation operand width
- `DIN1_WIDTH`, 12, signed weight operand width
- `ACC_WIDTH`, 40, signed accumulator width; must be >= DIN0_WIDTH+DIN1_WIDTH
- `DOUT_WIDTH`, 24, signed result width; must be <= ACC_WIDTH
- `SHIFT`, 8, arithmetic right shift applied to the final sum (0..ACC_WIDTH-1)
- `NUM_STAGE`, 2, product pipeline registers (1..4)
- `ap_clk` in 1, sole clock, rising edge
- `ap_rst` in 1, asynchronous, active-high reset
- `in_valid` in 1, operand beat valid
- `in_ready` out 1, beat accepted on an edge where in_valid && in_ready
- `din0` in DIN0_WIDTH, signed operand
- `din1` in DIN1_WIDTH, signed operand
- `in_last` in 1, final beat of the current dot product
- `out_valid` out 1, result valid
- `out_ready` in 1, result consumed on an edge where out_valid && out_ready
- `dout` out DOUT_WIDTH, scaled, saturated signed sum
- `out_ovf` out 1, dout was saturated

## Operation
- The product is the full-width signed din0*din1 (DIN0_WIDTH+DIN1_WIDTH bits), sign-extended to ACC_WIDTH.
- Each pipeline stage carries a valid bit and a last bit, so bubbles (in_valid low) do not alter the sum.
- Accumulator FSM:
  - ACC_IDLE: acc = 0.
  - A valid product moves the FSM to ACC_RUN with acc = product.
  - In ACC_RUN, acc += product.
  - A product tagged last computes sum = acc + product (acc = 0 in IDLE), loads the output register, and returns the FSM to ACC_IDLE with acc cleared.
  - Back-to-back vectors are supported with no idle cycle.
- Accumulator overflow wraps modulo 2^ACC_WIDTH. It is not flagged; sizing ACC_WIDTH is the user's job.
- Scaling: scaled = sum >>> SHIFT (arithmetic), with rounding per Configuration.
- Saturation: if scaled > 2^(DOUT_WIDTH-1)-1 or scaled < -2^(DOUT_WIDTH-1), dout is clamped to that bound and out_ovf=1. Otherwise out_ovf=0.
- Stall: enable = !(out_valid && !out_ready). When enable is low, every pipeline register, acc and the FSM hold.
- in_ready = enable && !ap_rst. It is combinational from out_ready.
- Output: out_valid, dout and out_ovf stay stable while out_valid && !out_ready. out_valid clears on consumption unless a new result loads on the same edge.

## Timing
- Reset values: out_valid=0, dout=0, out_ovf=0, acc=0, FSM=ACC_IDLE, all stage valid bits 0. in_ready=0 while ap_rst is high and 1 in the first cycle after release.
- Latency: a last beat accepted at edge k drives out_valid high after edge k+NUM_STAGE when no stall occurs. Stall cycles add one cycle each.
- Throughput: one beat per cycle while out_ready is high.
- Reset asserted mid-vector discards the partial sum and all in-flight beats. The first post-reset vector starts from zero.
- Simultaneous consume and new result on the same edge: the new result loads and out_valid stays 1.

## Configuration
- `CNN_MAC_ROUND_EN` defined: round-half-up, scaled = (sum + 2^(SHIFT-1)) >>> SHIFT when SHIFT > 0. Saturation is applied after rounding.
- Not defined: truncation toward negative infinity, scaled = sum >>> SHIFT.

## Test plan
All values use default parameters.
- Single beat (300, -200, last=1):
  - sum -60000; with ROUND_EN dout=-234, without it dout=-235; out_ovf=0.
  - out_valid rises 2 cycles after acceptance.
- Three-beat vector (100,10), (-50,4), (7,7, last) with in_valid gaps between beats:
  - sum 849, dout=3, out_ovf=0, exactly one result.
- 40 beats of (32767, 2047), last on beat 40:
  - sum 2,682,961,960, dout=8388607, out_ovf=1.
- 40 beats of (-32768, 2047):
  - dout=-8388608, out_ovf=1.
- Two single-beat vectors (16,16) then (32,16) with out_ready held low for 5 cycles:
  - dout holds 1 and in_ready stays 0 while stalled.
  - After release, results are 1 then 2, in order, with no loss or duplication.
- Reset mid-vector: accept 2 beats of (1000,1000) without last, pulse ap_rst, then send (16,16,last):
  - dout=1 (partial sum discarded); all outputs read 0 during reset.
